operand_collector: RTL

OPERAND_COLLECTOR -- requirements
Module: operand_collector

---
 rtl/core_pkg.sv | 26 ++
 rtl/operand_bypass.sv | 26 ++
 rtl/operand_collector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants and encodings for the operand collector and its bypass helper.
package core_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ1 = 2'd1,
    READ2 = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NSRC_0 = 2'd0,
    NSRC_1 = 2'd1,
    NSRC_2 = 2'd2
  } nsrc_e;

  // The raw encoding 3 behaves exactly like two sources.
  function automatic nsrc_e decode_nsrc(input logic [1:0] raw);
    return (raw == 2'd3) ? NSRC_2 : nsrc_e'(raw);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Write-port bypass select: returns the snooped write data when it targets the
// given source address, otherwise the supplied base value.
module operand_bypass #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int ADDR_W = core_pkg::ADDR_W,
  parameter int REG_W  = core_pkg::REG_W
) (
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] base_data,
  input  logic              wb_write_enable,
  input  logic [ADDR_W-1:0] wb_write_address,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic [DATA_W-1:0] sel_data
);

  localparam logic [ADDR_W-1:0] REG_MASK = ADDR_W'((1 << REG_W) - 1);

  logic upper_clear;
  logic hit;

  // Writes to addresses outside the architectural register range never alias a source.
  assign upper_clear = ((wb_write_address & ~REG_MASK) == '0);
  assign hit         = wb_write_enable && upper_clear && (wb_write_address == src_addr);
  assign sel_data    = hit ? wb_write_data : base_data;

endmodule

// File: rtl/operand_collector.sv
// Operand collector: accepts a decoded instruction, reads up to two sources through
// a single register-file port with write bypass/snoop, and hands the bundle to execute.
module operand_collector #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int ADDR_W = core_pkg::ADDR_W,
  parameter int REG_W  = core_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [1:0]        in_nsrc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [7:0]        in_ctrl,

  output logic [ADDR_W-1:0] rf_read_address,
  input  logic [DATA_W-1:0] rf_read_data,

  input  logic              wb_write_enable,
  input  logic [ADDR_W-1:0] wb_write_address,
  input  logic [DATA_W-1:0] wb_write_data,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_W-1:0]  out_rd,
  output logic [7:0]        out_ctrl
);

  import core_pkg::*;

  state_e             state_q, state_d;
  nsrc_e              nsrc_q,  nsrc_d;
  logic [REG_W-1:0]   rs1_q,   rs1_d;
  logic [REG_W-1:0]   rs2_q,   rs2_d;
  logic [REG_W-1:0]   rd_q,    rd_d;
  logic [DATA_W-1:0]  imm_q,   imm_d;
  logic [7:0]         ctrl_q,  ctrl_d;
  logic [DATA_W-1:0]  op1_q,   op1_d;
  logic [DATA_W-1:0]  op2_q,   op2_d;

  logic [ADDR_W-1:0]  rs1_addr;
  logic [ADDR_W-1:0]  rs2_addr;
  logic [DATA_W-1:0]  capture_data;
  logic [DATA_W-1:0]  snoop1_data;
  logic [DATA_W-1:0]  snoop2_data;
  logic               accept;

  assign rs1_addr = ADDR_W'(rs1_q);
  assign rs2_addr = ADDR_W'(rs2_q);

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);

  assign out_op1  = op1_q;
  assign out_op2  = op2_q;
  assign out_imm  = imm_q;
  assign out_rd   = rd_q;
  assign out_ctrl = ctrl_q;

  // Kept apart from the next-state logic so the capture path has no combinational loop.
  always_comb begin
    rf_read_address = '0;
    case (state_q)
      READ1:   rf_read_address = rs1_addr;
      READ2:   rf_read_address = rs2_addr;
      default: rf_read_address = '0;
    endcase
  end

  operand_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_capture_bypass (
    .src_addr         (rf_read_address),
    .base_data        (rf_read_data),
    .wb_write_enable  (wb_write_enable),
    .wb_write_address (wb_write_address),
    .wb_write_data    (wb_write_data),
    .sel_data         (capture_data)
  );

  // Snoop instances use the held operand as the fallback, so a miss keeps it unchanged.
  operand_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_snoop1_bypass (
    .src_addr         (rs1_addr),
    .base_data        (op1_q),
    .wb_write_enable  (wb_write_enable),
    .wb_write_address (wb_write_address),
    .wb_write_data    (wb_write_data),
    .sel_data         (snoop1_data)
  );

  operand_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_snoop2_bypass (
    .src_addr         (rs2_addr),
    .base_data        (op2_q),
    .wb_write_enable  (wb_write_enable),
    .wb_write_address (wb_write_address),
    .wb_write_data    (wb_write_data),
    .sel_data         (snoop2_data)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    nsrc_d  = nsrc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    op1_d   = op1_q;
    op2_d   = op2_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          rd_d    = in_rd;
          nsrc_d  = decode_nsrc(in_nsrc);
          imm_d   = in_imm;
          ctrl_d  = in_ctrl;
          op1_d   = '0;
          op2_d   = '0;
          state_d = (decode_nsrc(in_nsrc) == NSRC_0) ? HOLD : READ1;
        end
      end

      READ1: begin
        op1_d   = capture_data;
        state_d = (nsrc_q == NSRC_2) ? READ2 : HOLD;
      end

      READ2: begin
        op1_d   = snoop1_data;
        op2_d   = capture_data;
        state_d = HOLD;
      end

      HOLD: begin
        // Operands beyond nsrc stay zero even if a write hits their index.
        if (nsrc_q != NSRC_0) op1_d = snoop1_data;
        if (nsrc_q == NSRC_2) op2_d = snoop2_data;
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bundle registers are reset because they drive outputs that must read zero after reset.
      state_q <= IDLE;
      nsrc_q  <= NSRC_0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      nsrc_q  <= nsrc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

endmodule
